message_word_feeder: RTL and testbench

- Upstream stage of Preprocessing in Mining_2.0.
- Buffers a host-written message, then drives `message`, `indirizzo`, `mess_lenght`, `start` and `stopw` into Mining_FSM/Preprocessing.
- Streams one 32-bit word per cycle while the mining FSM reports the load state.
- Replaces the ad-hoc word-feeding logic currently living in the mining bench.

---
 rtl/message_word_feeder.sv | 126 ++++++++++++
 tb/tb_message_word_feeder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/message_word_feeder.sv
// rtl/message_word_feeder.sv - buffers a host message and feeds it one word per LOAD_STATE cycle to Mining_FSM/Preprocessing (option: FEEDER_BYTE_SWAP_EN)
module message_word_feeder #(
    parameter int         MAX_WORDS  = 64,
    parameter int         PTR_W      = 10,
    parameter logic [2:0] LOAD_STATE = 3'b001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        wr_last,
    input  logic [5:0]  wr_bits,
    output logic        wr_ready,
    output logic        overflow,
    input  logic [2:0]  state,
    input  logic        fine,
    output logic        start,
    output logic        stopw,
    output logic [31:0] message,
    output logic [6:0]  indirizzo,
    output logic [14:0] mess_lenght
);

    localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, STREAM, DONE} fsm_t;

    fsm_t             fsm;
    logic [31:0]      mem [0:MAX_WORDS-1];
    logic [PTR_W-1:0] wcnt;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wcnt_final;
    logic             load;
    logic             full;
    logic             wr_take;
    logic             wr_drop;
    logic [5:0]       last_bits;
    logic [14:0]      len_calc;
    logic [31:0]      rd_word;
    logic [31:0]      out_word;

    // wr_ready is registered, so acceptance follows it rather than the raw FSM state
    assign load       = (state == LOAD_STATE);
    assign full       = (wcnt == PTR_W'(MAX_WORDS));
    assign wr_take    = wr_en && wr_ready && !full;
    assign wr_drop    = wr_en && wr_ready && full;
    assign wcnt_final = wr_take ? wcnt + 1'b1 : wcnt;
    assign last_bits  = (wr_bits == 6'd0) ? 6'd32 : wr_bits;
    assign len_calc   = (15'(wcnt_final - 1'b1) << 5) + 15'(last_bits);
    assign rd_word    = mem[rptr[AW-1:0]];

`ifdef FEEDER_BYTE_SWAP_EN
    assign out_word = {rd_word[7:0], rd_word[15:8], rd_word[23:16], rd_word[31:24]};
`else
    assign out_word = rd_word;
`endif

    always_ff @(posedge clock) begin
        if (wr_take) begin
            mem[wcnt[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm         <= IDLE;
            wcnt        <= '0;
            rptr        <= '0;
            wr_ready    <= 1'b0;
            overflow    <= 1'b0;
            start       <= 1'b0;
            stopw       <= 1'b0;
            message     <= '0;
            indirizzo   <= '0;
            mess_lenght <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    wr_ready <= 1'b1;
                    if (wr_take) begin
                        wcnt <= wcnt + 1'b1;
                    end
                    if (wr_drop) begin
                        overflow <= 1'b1;
                    end
                    if ((wr_take || wr_drop) && wr_last) begin
                        mess_lenght <= len_calc;
                        start       <= 1'b1;
                        stopw       <= 1'b0;
                        rptr        <= '0;
                        indirizzo   <= '0;
                        wr_ready    <= 1'b0;
                        fsm         <= ARMED;
                    end
                end
                // ARMED always has rptr=0 < wcnt, so it shares the emit path with STREAM
                ARMED, STREAM: begin
                    if (load) begin
                        if (rptr == wcnt) begin
                            start <= 1'b0;
                            stopw <= 1'b1;
                            fsm   <= DONE;
                        end else begin
                            message <= out_word;
                            rptr    <= rptr + 1'b1;
                            if (rptr[3:0] == 4'hF) begin
                                indirizzo <= indirizzo + 1'b1;
                            end
                            fsm <= STREAM;
                        end
                    end
                end
                DONE: begin
                    if (fine) begin
                        wcnt     <= '0;
                        stopw    <= 1'b0;
                        wr_ready <= 1'b1;
                        fsm      <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_message_word_feeder.sv
// tb/tb_message_word_feeder.sv - directed self-checking bench for message_word_feeder
module tb_message_word_feeder;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_last;
    logic [5:0]  wr_bits;
    logic [2:0]  state;
    logic        fine;

    logic        wr_ready, overflow, start, stopw;
    logic [31:0] message;
    logic [6:0]  indirizzo;
    logic [14:0] mess_lenght;

    logic        wr_ready4, overflow4, start4, stopw4;
    logic [31:0] message4;
    logic [6:0]  indirizzo4;
    logic [14:0] mess_lenght4;

    int total = 0;
    int bad   = 0;

    message_word_feeder #(.MAX_WORDS(64), .PTR_W(10), .LOAD_STATE(3'b001)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
        .wr_bits(wr_bits), .wr_ready(wr_ready), .overflow(overflow), .state(state), .fine(fine),
        .start(start), .stopw(stopw), .message(message), .indirizzo(indirizzo),
        .mess_lenght(mess_lenght)
    );

    message_word_feeder #(.MAX_WORDS(4), .PTR_W(10), .LOAD_STATE(3'b001)) dut4 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
        .wr_bits(wr_bits), .wr_ready(wr_ready4), .overflow(overflow4), .state(state), .fine(fine),
        .start(start4), .stopw(stopw4), .message(message4), .indirizzo(indirizzo4),
        .mess_lenght(mess_lenght4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_val(input int i);
        return 32'h0102_0300 + 32'(i);
    endfunction

    function automatic logic [31:0] exp_w(input logic [31:0] w);
`ifdef FEEDER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        state = 3'b000; fine = 1'b0; wr_en = 1'b0; wr_last = 1'b0; wr_bits = 6'd0; wr_data = '0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic write_word(input logic [31:0] d, input logic last, input logic [5:0] bits);
        wr_en = 1'b1; wr_data = d; wr_last = last; wr_bits = bits;
        tick();
        wr_en = 1'b0; wr_last = 1'b0; wr_bits = 6'd0;
    endtask

    task automatic test_reset();
        state = 3'b000; fine = 1'b0; wr_en = 1'b0; wr_last = 1'b0; wr_bits = 6'd0; wr_data = '0;
        reset = 1'b0;
        tick();
        tick();
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset wr_ready: got %b want 0", wr_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
        total++; if (start !== 1'b0 || stopw !== 1'b0) begin bad++; $display("FAIL reset start/stopw: got %b/%b want 0/0", start, stopw); end
        total++; if (message !== 32'h0) begin bad++; $display("FAIL reset message: got %h want 0", message); end
        total++; if (indirizzo !== 7'd0 || mess_lenght !== 15'd0) begin bad++; $display("FAIL reset idx/len: got %0d/%0d want 0/0", indirizzo, mess_lenght); end
        reset = 1'b1;
        tick();
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL idle wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_single_word();
        do_reset();
        write_word(32'h0000_0000, 1'b1, 6'd1);
        total++; if (mess_lenght !== 15'd1) begin bad++; $display("FAIL single len: got %0d want 1", mess_lenght); end
        total++; if (start !== 1'b1 || stopw !== 1'b0) begin bad++; $display("FAIL single armed start/stopw: got %b/%b want 1/0", start, stopw); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL single wr_ready: got %b want 0", wr_ready); end
        state = 3'b001;
        tick();
        total++; if (message !== 32'h0 || start !== 1'b1) begin bad++; $display("FAIL single word0: got %h/%b want 0/1", message, start); end
        tick();
        total++; if (start !== 1'b0 || stopw !== 1'b1) begin bad++; $display("FAIL single end start/stopw: got %b/%b want 0/1", start, stopw); end
        total++; if (indirizzo !== 7'd0) begin bad++; $display("FAIL single idx: got %0d want 0", indirizzo); end
        state = 3'b000;
    endtask

    task automatic test_stream17();
        do_reset();
        for (int i = 0; i < 17; i++) write_word(word_val(i), (i == 16), (i == 16) ? 6'd32 : 6'd0);
        total++; if (mess_lenght !== 15'd544) begin bad++; $display("FAIL s17 len: got %0d want 544", mess_lenght); end
        state = 3'b001;
        for (int i = 0; i < 17; i++) begin
            tick();
            total++; if (message !== exp_w(word_val(i))) begin bad++; $display("FAIL s17 word%0d: got %h want %h", i, message, exp_w(word_val(i))); end
            total++; if (indirizzo !== ((i >= 15) ? 7'd1 : 7'd0)) begin bad++; $display("FAIL s17 idx at word%0d: got %0d want %0d", i, indirizzo, (i >= 15) ? 1 : 0); end
            total++; if (stopw !== 1'b0) begin bad++; $display("FAIL s17 early stopw at word%0d: got %b want 0", i, stopw); end
        end
        tick();
        total++; if (stopw !== 1'b1 || start !== 1'b0) begin bad++; $display("FAIL s17 end stopw/start: got %b/%b want 1/0", stopw, start); end
        total++; if (message !== exp_w(word_val(16))) begin bad++; $display("FAIL s17 hold last: got %h want %h", message, exp_w(word_val(16))); end
        state = 3'b000;
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 6; i++) write_word(word_val(i + 40), (i == 5), (i == 5) ? 6'd32 : 6'd0);
        state = 3'b001;
        for (int i = 0; i < 3; i++) tick();
        total++; if (message !== exp_w(word_val(42))) begin bad++; $display("FAIL stall pre: got %h want %h", message, exp_w(word_val(42))); end
        state = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (message !== exp_w(word_val(42))) begin bad++; $display("FAIL stall hold%0d: got %h want %h", i, message, exp_w(word_val(42))); end
        end
        state = 3'b001;
        for (int i = 3; i < 6; i++) begin
            tick();
            total++; if (message !== exp_w(word_val(i + 40)) || stopw !== 1'b0) begin bad++; $display("FAIL stall resume word%0d: got %h/%b want %h/0", i, message, stopw, exp_w(word_val(i + 40))); end
        end
        tick();
        total++; if (stopw !== 1'b1 || start !== 1'b0) begin bad++; $display("FAIL stall end stopw/start: got %b/%b want 1/0", stopw, start); end
        state = 3'b000;
    endtask

    task automatic test_return_idle();
        tick();
        total++; if (stopw !== 1'b1 || wr_ready !== 1'b0) begin bad++; $display("FAIL done hold stopw/wr_ready: got %b/%b want 1/0", stopw, wr_ready); end
        fine = 1'b1;
        tick();
        fine = 1'b0;
        total++; if (wr_ready !== 1'b1 || stopw !== 1'b0 || start !== 1'b0) begin bad++; $display("FAIL idle return rdy/stopw/start: got %b/%b/%b want 1/0/0", wr_ready, stopw, start); end
        total++; if (message !== exp_w(word_val(45)) || mess_lenght !== 15'd192) begin bad++; $display("FAIL idle held msg/len: got %h/%0d want %h/192", message, mess_lenght, exp_w(word_val(45))); end
        write_word(32'hDEAD_BEEF, 1'b0, 6'd0);
        write_word(32'h0BAD_F00D, 1'b1, 6'd16);
        total++; if (mess_lenght !== 15'd48 || start !== 1'b1 || indirizzo !== 7'd0) begin bad++; $display("FAIL re-armed len/start/idx: got %0d/%b/%0d want 48/1/0", mess_lenght, start, indirizzo); end
        fine = 1'b1;
        tick();
        fine = 1'b0;
        write_word(32'h1234_5678, 1'b1, 6'd1);
        total++; if (start !== 1'b1 || mess_lenght !== 15'd48 || overflow !== 1'b0) begin bad++; $display("FAIL armed ignore start/len/ovf: got %b/%0d/%b want 1/48/0", start, mess_lenght, overflow); end
        state = 3'b001;
        tick();
        total++; if (message !== exp_w(32'hDEAD_BEEF)) begin bad++; $display("FAIL re word0: got %h want %h", message, exp_w(32'hDEAD_BEEF)); end
        tick();
        total++; if (message !== exp_w(32'h0BAD_F00D)) begin bad++; $display("FAIL re word1: got %h want %h", message, exp_w(32'h0BAD_F00D)); end
        tick();
        total++; if (stopw !== 1'b1) begin bad++; $display("FAIL re end stopw: got %b want 1", stopw); end
        state = 3'b000;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) write_word(word_val(i + 80), (i == 4), (i == 4) ? 6'd8 : 6'd0);
        total++; if (overflow4 !== 1'b1) begin bad++; $display("FAIL ovf flag: got %b want 1", overflow4); end
        total++; if (mess_lenght4 !== 15'd104) begin bad++; $display("FAIL ovf len: got %0d want 104", mess_lenght4); end
        total++; if (overflow !== 1'b0 || mess_lenght !== 15'd136) begin bad++; $display("FAIL deep ovf/len: got %b/%0d want 0/136", overflow, mess_lenght); end
        state = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (message4 !== exp_w(word_val(i + 80)) || stopw4 !== 1'b0) begin bad++; $display("FAIL ovf word%0d: got %h/%b want %h/0", i, message4, stopw4, exp_w(word_val(i + 80))); end
        end
        tick();
        total++; if (stopw4 !== 1'b1 || message4 !== exp_w(word_val(83))) begin bad++; $display("FAIL ovf end stopw/msg: got %b/%h want 1/%h", stopw4, message4, exp_w(word_val(83))); end
        state = 3'b000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 20; i++) write_word(word_val(i + 100), (i == 19), (i == 19) ? 6'd32 : 6'd0);
        state = 3'b001;
        for (int i = 0; i < 17; i++) tick();
        total++; if (message !== exp_w(word_val(116)) || indirizzo !== 7'd1) begin bad++; $display("FAIL mid pre msg/idx: got %h/%0d want %h/1", message, indirizzo, exp_w(word_val(116))); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (message !== 32'h0 || start !== 1'b0 || stopw !== 1'b0) begin bad++; $display("FAIL mid async msg/start/stopw: got %h/%b/%b want 0/0/0", message, start, stopw); end
        total++; if (indirizzo !== 7'd0 || mess_lenght !== 15'd0 || wr_ready !== 1'b0) begin bad++; $display("FAIL mid async idx/len/rdy: got %0d/%0d/%b want 0/0/0", indirizzo, mess_lenght, wr_ready); end
        tick();
        state = 3'b000;
        reset = 1'b1;
        tick();
        total++; if (wr_ready !== 1'b1 || start !== 1'b0 || message !== 32'h0) begin bad++; $display("FAIL mid idle rdy/start/msg: got %b/%b/%h want 1/0/0", wr_ready, start, message); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream17();
        test_stall();
        test_return_idle();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
